// File: rtl/srisc_ctrl_pkg.sv
// Shared types and encodings for the Simple RISC Machine multicycle controller.
// Holds the state and instruction-class enums, the IR field codes, the
// datapath/memory select encodings, and the instruction-class decoder.
package srisc_ctrl_pkg;

  localparam int unsigned OPC_W  = 3;
  localparam int unsigned OP_W   = 2;
  localparam int unsigned COND_W = 3;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned NSEL_W = 3;

  // Controller states
  typedef enum logic [4:0] {
    S_RST,
    S_IF,
    S_UPD_PC,
    S_DEC,
    S_WB_IMM,
    S_LD_A,
    S_LD_B,
    S_EXEC,
    S_WB,
    S_CMP,
    S_ADDR,
    S_LD_ADDR,
    S_MEM_RD,
    S_MEM_WR,
    S_PASS,
    S_BR_CALC,
    S_BR_LOAD,
    S_LINK,
    S_HALT,
    S_ERR
  } state_e;

  // Instruction classes; members of a class share one state sequence
  typedef enum logic [3:0] {
    C_MOVI,
    C_MOV,   // MOV reg and MVN
    C_ALU,   // ADD and AND
    C_CMP,
    C_LDR,
    C_STR,
    C_BCC,
    C_BL,
    C_BX,
    C_BLX,
    C_HALT,
    C_ILL
  } iclass_e;

  // opcode field
  localparam logic [OPC_W-1:0] OPC_BR   = 3'b001;
  localparam logic [OPC_W-1:0] OPC_LINK = 3'b010;
  localparam logic [OPC_W-1:0] OPC_LDR  = 3'b011;
  localparam logic [OPC_W-1:0] OPC_STR  = 3'b100;
  localparam logic [OPC_W-1:0] OPC_ALU  = 3'b101;
  localparam logic [OPC_W-1:0] OPC_MOV  = 3'b110;
  localparam logic [OPC_W-1:0] OPC_HALT = 3'b111;

  // op field
  localparam logic [OP_W-1:0] OP_MOV   = 2'b00;
  localparam logic [OP_W-1:0] OP_MOVI  = 2'b10;
  localparam logic [OP_W-1:0] OP_LDST  = 2'b00;
  localparam logic [OP_W-1:0] ALU_ADD  = 2'b00;
  localparam logic [OP_W-1:0] ALU_CMP  = 2'b01;
  localparam logic [OP_W-1:0] ALU_AND  = 2'b10;
  localparam logic [OP_W-1:0] ALU_MVN  = 2'b11;
  localparam logic [OP_W-1:0] OP_BX    = 2'b00;
  localparam logic [OP_W-1:0] OP_BLX   = 2'b10;
  localparam logic [OP_W-1:0] OP_BL    = 2'b11;

  // cond field
  localparam logic [COND_W-1:0] COND_B   = 3'b000;
  localparam logic [COND_W-1:0] COND_BEQ = 3'b001;
  localparam logic [COND_W-1:0] COND_BNE = 3'b010;
  localparam logic [COND_W-1:0] COND_BLT = 3'b011;
  localparam logic [COND_W-1:0] COND_BLE = 3'b100;

  // mem_cmd
  localparam logic [SEL_W-1:0] MEM_NONE  = 2'b00;
  localparam logic [SEL_W-1:0] MEM_READ  = 2'b01;
  localparam logic [SEL_W-1:0] MEM_WRITE = 2'b10;

  // vsel
  localparam logic [SEL_W-1:0] VSEL_C     = 2'b00;
  localparam logic [SEL_W-1:0] VSEL_MDATA = 2'b01;
  localparam logic [SEL_W-1:0] VSEL_IMM8  = 2'b10;
  localparam logic [SEL_W-1:0] VSEL_PC    = 2'b11;

  // asel
  localparam logic [SEL_W-1:0] ASEL_REG  = 2'b00;
  localparam logic [SEL_W-1:0] ASEL_ZERO = 2'b01;
  localparam logic [SEL_W-1:0] ASEL_PC   = 2'b10;

  // bsel
  localparam logic [SEL_W-1:0] BSEL_REG  = 2'b00;
  localparam logic [SEL_W-1:0] BSEL_IMM5 = 2'b01;
  localparam logic [SEL_W-1:0] BSEL_IMM8 = 2'b10;

  // sel_pc
  localparam logic [SEL_W-1:0] PC_RST = 2'b00;
  localparam logic [SEL_W-1:0] PC_INC = 2'b01;
  localparam logic [SEL_W-1:0] PC_C   = 2'b10;

  // nsel (one-hot register select)
  localparam logic [NSEL_W-1:0] NSEL_NONE = 3'b000;
  localparam logic [NSEL_W-1:0] NSEL_RN   = 3'b001;
  localparam logic [NSEL_W-1:0] NSEL_RD   = 3'b010;
  localparam logic [NSEL_W-1:0] NSEL_RM   = 3'b100;

  // Map IR fields to an instruction class; anything unrecognised is C_ILL
  function automatic iclass_e decode_insn(input logic [OPC_W-1:0]  opcode,
                                          input logic [OP_W-1:0]   op,
                                          input logic [COND_W-1:0] cond,
                                          input logic              link_en);
    iclass_e c;
    c = C_ILL;
    case (opcode)
      OPC_MOV: begin
        if (op == OP_MOVI)     c = C_MOVI;
        else if (op == OP_MOV) c = C_MOV;
      end
      OPC_ALU: begin
        case (op)
          ALU_CMP: c = C_CMP;
          ALU_MVN: c = C_MOV;
          default: c = C_ALU;
        endcase
      end
      OPC_LDR: if (op == OP_LDST) c = C_LDR;
      OPC_STR: if (op == OP_LDST) c = C_STR;
      OPC_BR:  if (cond <= COND_BLE) c = C_BCC;
      OPC_LINK: begin
        if (link_en) begin
          case (op)
            OP_BL:   c = C_BL;
            OP_BX:   c = C_BX;
            OP_BLX:  c = C_BLX;
            default: c = C_ILL;
          endcase
        end
      end
      OPC_HALT: c = C_HALT;
      default:  c = C_ILL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/srisc_ctrl_fsm_branch_eval.sv
// Conditional-branch evaluator.
// Ports: cond (IR[10:8]), Z/N/V status flags in; taken out (combinational).
// Codes outside B..BLE report not-taken; legality is decided by the decoder.
module srisc_branch_eval
  import srisc_ctrl_pkg::*;
(
  input  logic [COND_W-1:0] cond,
  input  logic              Z,
  input  logic              N,
  input  logic              V,
  output logic              taken
);

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_B:   taken = 1'b1;
      COND_BEQ: taken = Z;
      COND_BNE: taken = ~Z;
      COND_BLT: taken = N ^ V;
      COND_BLE: taken = (N ^ V) | Z;
      default:  taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/srisc_ctrl_fsm.sv
// Multicycle control FSM for the Simple RISC Machine.
// Ports: clk, rst (sync, active-high); IR fields opcode/op/cond; Z/N/V flags;
//   mem_ready handshake.  Outputs: datapath selects (nsel, vsel, asel, bsel),
//   datapath enables (loada, loadb, loadc, loads, write), PC/IR/address control
//   (sel_pc, load_pc, load_ir, load_addr, addr_sel), mem_cmd, halted, err.
// Outputs are a decode of the state register; load_ir and write additionally
// follow mem_ready while waiting on memory.
module srisc_ctrl_fsm #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter bit          ENABLE_LINK = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  input  logic [2:0] cond,
  input  logic       Z,
  input  logic       N,
  input  logic       V,
  input  logic       mem_ready,
  output logic [2:0] nsel,
  output logic [1:0] vsel,
  output logic [1:0] asel,
  output logic [1:0] bsel,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       write,
  output logic [1:0] sel_pc,
  output logic       load_pc,
  output logic       load_ir,
  output logic       load_addr,
  output logic       addr_sel,
  output logic [1:0] mem_cmd,
  output logic       halted,
  output logic       err
);

  import srisc_ctrl_pkg::*;

  // Wait counter only needs to reach MEM_TIMEOUT-1 before the FSM leaves
  localparam int unsigned   CNT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
  localparam bit            TO_EN    = (MEM_TIMEOUT != 0);

  state_e           state, state_next;
  iclass_e          cls, cls_next, dec_cls;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_next;
  logic             taken;
  logic             waiting;
  logic             timeout;

  srisc_branch_eval u_branch_eval (
    .cond  (cond),
    .Z     (Z),
    .N     (N),
    .V     (V),
    .taken (taken)
  );

  assign dec_cls = decode_insn(opcode, op, cond, ENABLE_LINK);

  // State, latched instruction class and memory wait counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_RST;
      cls      <= C_ILL;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      cls      <= cls_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // Next-state and Moore output decode
  always_comb begin
    state_next = state;
    cls_next   = cls;
    nsel       = NSEL_NONE;
    vsel       = VSEL_C;
    asel       = ASEL_REG;
    bsel       = BSEL_REG;
    loada      = 1'b0;
    loadb      = 1'b0;
    loadc      = 1'b0;
    loads      = 1'b0;
    write      = 1'b0;
    sel_pc     = PC_RST;
    load_pc    = 1'b0;
    load_ir    = 1'b0;
    load_addr  = 1'b0;
    addr_sel   = 1'b0;
    mem_cmd    = MEM_NONE;
    halted     = 1'b0;
    err        = 1'b0;

    waiting = (state == S_IF) || (state == S_MEM_RD) || (state == S_MEM_WR);
    // mem_ready in the final wait cycle completes instead of timing out
    timeout = TO_EN && waiting && !mem_ready && (wait_cnt == CNT_LAST);

    case (state)
      S_RST: begin
        sel_pc     = PC_RST;
        load_pc    = 1'b1;
        state_next = S_IF;
      end
      S_IF: begin
        addr_sel = 1'b1;
        mem_cmd  = MEM_READ;
        load_ir  = mem_ready;
        if (mem_ready)    state_next = S_UPD_PC;
        else if (timeout) state_next = S_ERR;
      end
      S_UPD_PC: begin
        sel_pc     = PC_INC;
        load_pc    = 1'b1;
        state_next = S_DEC;
      end
      S_DEC: begin
        // Class is held for the rest of the instruction; flags are used only here
        cls_next = dec_cls;
        case (dec_cls)
          C_MOVI:                state_next = S_WB_IMM;
          C_MOV, C_BX, C_BLX:    state_next = S_LD_B;
          C_ALU, C_CMP,
          C_LDR, C_STR:          state_next = S_LD_A;
          C_BCC:                 state_next = taken ? S_BR_CALC : S_IF;
          C_BL:                  state_next = S_LINK;
          C_HALT:                state_next = S_HALT;
          default:               state_next = S_ERR;
        endcase
      end
      S_WB_IMM: begin
        nsel       = NSEL_RN;
        vsel       = VSEL_IMM8;
        write      = 1'b1;
        state_next = S_IF;
      end
      S_LD_A: begin
        nsel       = NSEL_RN;
        loada      = 1'b1;
        state_next = (cls == C_LDR || cls == C_STR) ? S_ADDR : S_LD_B;
      end
      S_LD_B: begin
        // ALU-class ops read Rm; store/branch-register ops read Rd
        loadb = 1'b1;
        nsel  = (cls == C_MOV || cls == C_ALU || cls == C_CMP) ? NSEL_RM : NSEL_RD;
        case (cls)
          C_MOV, C_ALU: state_next = S_EXEC;
          C_CMP:        state_next = S_CMP;
          C_BLX:        state_next = S_LINK;
          default:      state_next = S_PASS;
        endcase
      end
      S_EXEC: begin
        asel       = (cls == C_MOV) ? ASEL_ZERO : ASEL_REG;
        bsel       = BSEL_REG;
        loadc      = 1'b1;
        state_next = S_WB;
      end
      S_WB: begin
        nsel       = NSEL_RD;
        vsel       = VSEL_C;
        write      = 1'b1;
        state_next = S_IF;
      end
      S_CMP: begin
        asel       = ASEL_REG;
        loads      = 1'b1;
        state_next = S_IF;
      end
      S_ADDR: begin
        bsel       = BSEL_IMM5;
        loadc      = 1'b1;
        state_next = S_LD_ADDR;
      end
      S_LD_ADDR: begin
        load_addr  = 1'b1;
        state_next = (cls == C_LDR) ? S_MEM_RD : S_LD_B;
      end
      S_MEM_RD: begin
        mem_cmd = MEM_READ;
        nsel    = NSEL_RD;
        vsel    = VSEL_MDATA;
        write   = mem_ready;
        if (mem_ready)    state_next = S_IF;
        else if (timeout) state_next = S_ERR;
      end
      S_MEM_WR: begin
        mem_cmd = MEM_WRITE;
        if (mem_ready)    state_next = S_IF;
        else if (timeout) state_next = S_ERR;
      end
      S_PASS: begin
        asel       = ASEL_ZERO;
        loadc      = 1'b1;
        state_next = (cls == C_STR) ? S_MEM_WR : S_BR_LOAD;
      end
      S_BR_CALC: begin
        asel       = ASEL_PC;
        bsel       = BSEL_IMM8;
        loadc      = 1'b1;
        state_next = S_BR_LOAD;
      end
      S_BR_LOAD: begin
        sel_pc     = PC_C;
        load_pc    = 1'b1;
        state_next = S_IF;
      end
      S_LINK: begin
        nsel       = NSEL_RN;
        vsel       = VSEL_PC;
        write      = 1'b1;
        state_next = (cls == C_BLX) ? S_PASS : S_BR_CALC;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      S_ERR: begin
        err     = 1'b1;
        mem_cmd = MEM_NONE;
      end
      default: state_next = S_ERR;
    endcase

    // Counter restarts on every state change, counts missed handshakes otherwise
    if (state_next != state)
      wait_cnt_next = '0;
    else if (TO_EN && waiting && !mem_ready)
      wait_cnt_next = wait_cnt + CNT_W'(1);
    else
      wait_cnt_next = wait_cnt;
  end

endmodule

// File: tb/tb_srisc_ctrl_fsm.sv
// Directed bench for srisc_ctrl_fsm. An instruction-level model pushes the
// expected per-cycle output word into a queue; drain pops one entry per cycle
// and compares it with the DUT. A second instance (link disabled, no timeout)
// shares the inputs and is spot-checked.
module tb_srisc_ctrl_fsm;

  typedef struct packed {
    logic [2:0] nsel;
    logic [1:0] vsel;
    logic [1:0] asel;
    logic [1:0] bsel;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       write;
    logic [1:0] sel_pc;
    logic       load_pc;
    logic       load_ir;
    logic       load_addr;
    logic       addr_sel;
    logic [1:0] mem_cmd;
    logic       halted;
    logic       err;
  } ov_t;

  typedef enum {
    T_RST, T_IF, T_UPD, T_DEC, T_WB_IMM, T_LDA, T_LDB_RM, T_LDB_RD,
    T_EXEC_MOV, T_EXEC_ALU, T_WB, T_CMP, T_ADDR, T_LD_ADDR, T_MEM_RD,
    T_MEM_WR, T_PASS, T_BR_CALC, T_BR_LOAD, T_LINK, T_HALT, T_ERR
  } tstate_e;

  typedef struct {
    logic  rst;
    logic  ready;
    ov_t   exp;
    string tag;
  } step_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, Z, N, V, mem_ready;
  logic [2:0] opcode, cond;
  logic [1:0] op;

  logic [2:0] nsel, n2_nsel;
  logic [1:0] vsel, asel, bsel, sel_pc, mem_cmd;
  logic [1:0] n2_vsel, n2_asel, n2_bsel, n2_sel_pc, n2_mem_cmd;
  logic loada, loadb, loadc, loads, write, load_pc, load_ir, load_addr, addr_sel, halted, err;
  logic n2_loada, n2_loadb, n2_loadc, n2_loads, n2_write, n2_load_pc, n2_load_ir;
  logic n2_load_addr, n2_addr_sel, n2_halted, n2_err;

  srisc_ctrl_fsm #(.MEM_TIMEOUT(4), .ENABLE_LINK(1'b1)) u_dut (
    .clk(clk), .rst(rst), .opcode(opcode), .op(op), .cond(cond),
    .Z(Z), .N(N), .V(V), .mem_ready(mem_ready),
    .nsel(nsel), .vsel(vsel), .asel(asel), .bsel(bsel),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads), .write(write),
    .sel_pc(sel_pc), .load_pc(load_pc), .load_ir(load_ir), .load_addr(load_addr),
    .addr_sel(addr_sel), .mem_cmd(mem_cmd), .halted(halted), .err(err)
  );

  srisc_ctrl_fsm #(.MEM_TIMEOUT(0), .ENABLE_LINK(1'b0)) u_nolink (
    .clk(clk), .rst(rst), .opcode(opcode), .op(op), .cond(cond),
    .Z(Z), .N(N), .V(V), .mem_ready(mem_ready),
    .nsel(n2_nsel), .vsel(n2_vsel), .asel(n2_asel), .bsel(n2_bsel),
    .loada(n2_loada), .loadb(n2_loadb), .loadc(n2_loadc), .loads(n2_loads),
    .write(n2_write), .sel_pc(n2_sel_pc), .load_pc(n2_load_pc),
    .load_ir(n2_load_ir), .load_addr(n2_load_addr), .addr_sel(n2_addr_sel),
    .mem_cmd(n2_mem_cmd), .halted(n2_halted), .err(n2_err)
  );

  ov_t got, got2;
  assign got  = {nsel, vsel, asel, bsel, loada, loadb, loadc, loads, write,
                 sel_pc, load_pc, load_ir, load_addr, addr_sel, mem_cmd, halted, err};
  assign got2 = {n2_nsel, n2_vsel, n2_asel, n2_bsel, n2_loada, n2_loadb, n2_loadc,
                 n2_loads, n2_write, n2_sel_pc, n2_load_pc, n2_load_ir,
                 n2_load_addr, n2_addr_sel, n2_mem_cmd, n2_halted, n2_err};

  step_t q[$];
  int    total = 0;
  int    bad   = 0;

  // Expected output word for each state, straight from the state table
  function automatic ov_t vec(input tstate_e s, input logic rdy);
    ov_t o;
    o = '0;
    case (s)
      T_RST:      o.load_pc = 1'b1;
      T_IF:       begin o.addr_sel = 1'b1; o.mem_cmd = 2'b01; o.load_ir = rdy; end
      T_UPD:      begin o.sel_pc = 2'b01; o.load_pc = 1'b1; end
      T_WB_IMM:   begin o.nsel = 3'b001; o.vsel = 2'b10; o.write = 1'b1; end
      T_LDA:      begin o.nsel = 3'b001; o.loada = 1'b1; end
      T_LDB_RM:   begin o.nsel = 3'b100; o.loadb = 1'b1; end
      T_LDB_RD:   begin o.nsel = 3'b010; o.loadb = 1'b1; end
      T_EXEC_MOV: begin o.asel = 2'b01; o.loadc = 1'b1; end
      T_EXEC_ALU: o.loadc = 1'b1;
      T_WB:       begin o.nsel = 3'b010; o.write = 1'b1; end
      T_CMP:      o.loads = 1'b1;
      T_ADDR:     begin o.bsel = 2'b01; o.loadc = 1'b1; end
      T_LD_ADDR:  o.load_addr = 1'b1;
      T_MEM_RD:   begin o.mem_cmd = 2'b01; o.nsel = 3'b010; o.vsel = 2'b01; o.write = rdy; end
      T_MEM_WR:   o.mem_cmd = 2'b10;
      T_PASS:     begin o.asel = 2'b01; o.loadc = 1'b1; end
      T_BR_CALC:  begin o.asel = 2'b10; o.bsel = 2'b10; o.loadc = 1'b1; end
      T_BR_LOAD:  begin o.sel_pc = 2'b10; o.load_pc = 1'b1; end
      T_LINK:     begin o.nsel = 3'b001; o.vsel = 2'b11; o.write = 1'b1; end
      T_HALT:     o.halted = 1'b1;
      T_ERR:      o.err = 1'b1;
      default:    o = '0;
    endcase
    return o;
  endfunction

  task automatic push(input tstate_e s, input logic rdy, input logic r);
    step_t t;
    t.rst   = r;
    t.ready = rdy;
    t.exp   = vec(s, rdy);
    t.tag   = s.name();
    q.push_back(t);
  endtask

  // Expected sequence for one instruction, zero-wait fetch, memw memory waits
  task automatic model(input logic [2:0] opc, input logic [1:0] o, input logic [2:0] c,
                       input logic z, input logic n, input logic v, input int memw);
    logic tk;
    push(T_IF, 1'b1, 1'b0);
    push(T_UPD, 1'b1, 1'b0);
    push(T_DEC, 1'b1, 1'b0);
    case ({opc, o})
      5'b11010: push(T_WB_IMM, 1'b1, 1'b0);
      5'b11000, 5'b10111: begin
        push(T_LDB_RM, 1'b1, 1'b0); push(T_EXEC_MOV, 1'b1, 1'b0); push(T_WB, 1'b1, 1'b0);
      end
      5'b10100, 5'b10110: begin
        push(T_LDA, 1'b1, 1'b0); push(T_LDB_RM, 1'b1, 1'b0);
        push(T_EXEC_ALU, 1'b1, 1'b0); push(T_WB, 1'b1, 1'b0);
      end
      5'b10101: begin
        push(T_LDA, 1'b1, 1'b0); push(T_LDB_RM, 1'b1, 1'b0); push(T_CMP, 1'b1, 1'b0);
      end
      5'b01100: begin
        push(T_LDA, 1'b1, 1'b0); push(T_ADDR, 1'b1, 1'b0); push(T_LD_ADDR, 1'b1, 1'b0);
        for (int i = 0; i < memw; i++) push(T_MEM_RD, 1'b0, 1'b0);
        push(T_MEM_RD, 1'b1, 1'b0);
      end
      5'b10000: begin
        push(T_LDA, 1'b1, 1'b0); push(T_ADDR, 1'b1, 1'b0); push(T_LD_ADDR, 1'b1, 1'b0);
        push(T_LDB_RD, 1'b1, 1'b0); push(T_PASS, 1'b1, 1'b0);
        for (int i = 0; i < memw; i++) push(T_MEM_WR, 1'b0, 1'b0);
        push(T_MEM_WR, 1'b1, 1'b0);
      end
      5'b00100, 5'b00101, 5'b00110, 5'b00111: begin
        case (c)
          3'd0:    tk = 1'b1;
          3'd1:    tk = z;
          3'd2:    tk = ~z;
          3'd3:    tk = n ^ v;
          default: tk = (n ^ v) | z;
        endcase
        if (tk) begin push(T_BR_CALC, 1'b1, 1'b0); push(T_BR_LOAD, 1'b1, 1'b0); end
      end
      5'b01011: begin
        push(T_LINK, 1'b1, 1'b0); push(T_BR_CALC, 1'b1, 1'b0); push(T_BR_LOAD, 1'b1, 1'b0);
      end
      5'b01000: begin
        push(T_LDB_RD, 1'b1, 1'b0); push(T_PASS, 1'b1, 1'b0); push(T_BR_LOAD, 1'b1, 1'b0);
      end
      5'b01010: begin
        push(T_LDB_RD, 1'b1, 1'b0); push(T_LINK, 1'b1, 1'b0);
        push(T_PASS, 1'b1, 1'b0); push(T_BR_LOAD, 1'b1, 1'b0);
      end
      default: ;  // HALT / illegal: caller pushes the terminal cycles
    endcase
  endtask

  // Pop n steps (all if n < 0): drive after posedge, compare at negedge
  task automatic drain(input int n);
    step_t s;
    int k;
    k = 0;
    while (q.size() > 0 && (n < 0 || k < n)) begin
      s = q.pop_front();
      rst = s.rst;
      mem_ready = s.ready;
      @(negedge clk);
      total++;
      assert (got === s.exp) else begin
        bad++;
        $error("FAIL %s: got=%h exp=%h", s.tag, got, s.exp);
      end
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic check2(input string tag, input ov_t e);
    total++;
    assert (got2 === e) else begin
      bad++;
      $error("FAIL %s: got=%h exp=%h", tag, got2, e);
    end
  endtask

  task automatic run(input logic [2:0] opc, input logic [1:0] o, input logic [2:0] c,
                     input logic z, input logic n, input logic v, input int memw);
    opcode = opc; op = o; cond = c; Z = z; N = n; V = v;
    model(opc, o, c, z, n, v, memw);
    drain(-1);
  endtask

  initial begin
    rst = 1'b1; mem_ready = 1'b1;
    opcode = 3'b000; op = 2'b00; cond = 3'b000; Z = 1'b0; N = 1'b0; V = 1'b0;
    @(posedge clk); #1;
    // second reset cycle, then the first cycle after release is still RST
    push(T_RST, 1'b1, 1'b1);
    push(T_RST, 1'b1, 1'b0);
    drain(-1);

    run(3'b110, 2'b10, 3'b000, 1'b0, 1'b0, 1'b0, 0);  // MOVI
    run(3'b101, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 0);  // ADD
    run(3'b110, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 0);  // MOV reg
    run(3'b101, 2'b11, 3'b000, 1'b0, 1'b0, 1'b0, 0);  // MVN
    run(3'b101, 2'b10, 3'b000, 1'b0, 1'b0, 1'b0, 0);  // AND
    run(3'b101, 2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 0);  // CMP
    run(3'b011, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 3);  // LDR, 3 waits
    run(3'b100, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 2);  // STR, 2 waits
    run(3'b001, 2'b00, 3'b001, 1'b0, 1'b0, 1'b0, 0);  // BEQ not taken
    run(3'b001, 2'b00, 3'b001, 1'b1, 1'b0, 1'b0, 0);  // BEQ taken
    run(3'b001, 2'b00, 3'b010, 1'b0, 1'b0, 1'b0, 0);  // BNE taken
    run(3'b001, 2'b00, 3'b011, 1'b0, 1'b1, 1'b1, 0);  // BLT not taken
    run(3'b001, 2'b00, 3'b011, 1'b0, 1'b1, 1'b0, 0);  // BLT taken
    run(3'b001, 2'b00, 3'b100, 1'b0, 1'b0, 1'b0, 0);  // BLE not taken
    run(3'b001, 2'b00, 3'b100, 1'b1, 1'b0, 1'b0, 0);  // BLE taken on Z
    run(3'b001, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 0);  // B

    // BLX: the link-disabled instance must be in ERR right after DEC
    opcode = 3'b010; op = 2'b10; cond = 3'b000;
    model(3'b010, 2'b10, 3'b000, 1'b0, 1'b0, 1'b0, 0);
    drain(3);
    check2("nolink_blx_err", vec(T_ERR, 1'b1));
    drain(-1);

    run(3'b010, 2'b11, 3'b000, 1'b0, 1'b0, 1'b0, 0);  // BL
    run(3'b010, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 0);  // BX

    // Illegal opcode: sticky ERR, cleared only by rst
    opcode = 3'b000; op = 2'b00;
    model(3'b000, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 0);
    push(T_ERR, 1'b0, 1'b0); push(T_ERR, 1'b1, 1'b0); push(T_ERR, 1'b1, 1'b1);
    push(T_RST, 1'b1, 1'b0);
    drain(-1);

    // Reserved branch condition
    opcode = 3'b001; op = 2'b00; cond = 3'b101;
    model(3'b000, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 0);
    push(T_ERR, 1'b1, 1'b0); push(T_ERR, 1'b1, 1'b1); push(T_RST, 1'b1, 1'b0);
    drain(-1);

    // HALT is terminal until rst
    opcode = 3'b111; op = 2'b01; cond = 3'b000;
    model(3'b111, 2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 0);
    push(T_HALT, 1'b1, 1'b0); push(T_HALT, 1'b0, 1'b0); push(T_HALT, 1'b1, 1'b1);
    push(T_RST, 1'b1, 1'b0);
    drain(-1);

    // Fetch timeout after 4 wait cycles; no-timeout instance keeps waiting
    for (int i = 0; i < 4; i++) push(T_IF, 1'b0, 1'b0);
    push(T_ERR, 1'b0, 1'b0); push(T_ERR, 1'b0, 1'b0);
    drain(-1);
    check2("notimeout_if_wait", vec(T_IF, 1'b0));
    push(T_ERR, 1'b0, 1'b1); push(T_RST, 1'b0, 1'b0);
    drain(-1);

    // rst in the middle of a fetch wait
    push(T_IF, 1'b0, 1'b0); push(T_IF, 1'b0, 1'b0); push(T_IF, 1'b0, 1'b1);
    push(T_RST, 1'b1, 1'b0);
    drain(-1);
    run(3'b110, 2'b10, 3'b000, 1'b0, 1'b0, 1'b0, 0);  // MOVI after recovery

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
